// File: rtl/video_timing_gen.sv
// Raster timing generator with a selectable test-pattern RGB source.
// Every output is registered and advances only on cen_i-qualified clock edges.
module video_timing_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic SYNC_POL = 1'b1,
  parameter int   GRID     = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [23:0] color_i,
  input  logic [15:0] seed_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        frame_start_o
);

  typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_GRID, PAT_NOISE} pat_e;

  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] GRID_LAST = 12'(GRID - 1);
  localparam logic [11:0] BAR_LAST  = 12'(H_ACTIVE / 8 - 1);

  logic [11:0] h_q, h_d, v_q, v_d;
  logic [11:0] gx_q, gx_d, gy_q, gy_d;
  logic [11:0] bx_q, bx_d;
  logic [2:0]  bar_q, bar_d;
  pat_e        pat_q, pat_d;
  logic [23:0] color_q, color_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic [1:0]  blank_q, blank_d;
  logic [2:0]  sync_q, sync_d;
  logic [23:0] rgb_q, rgb_d;
  logic        fs_q, fs_d;
  logic [11:0] x_q, y_q;

  logic        frame_start, hblank, vblank, de, h_wrap;
  logic [15:0] lfsr_cur;
  logic [23:0] bar_rgb;

  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    frame_start = (h_q == '0) && (v_q == '0);
    // At frame start the live selection is used directly so pixel (0,0) already shows it.
    pat_d    = frame_start ? pat_e'(pat_sel_i) : pat_q;
    color_d  = frame_start ? color_i : color_q;
    lfsr_cur = lfsr_q;
    if (frame_start) lfsr_cur = (seed_i == '0) ? 16'h0001 : seed_i;

    hblank = (h_q >= H_ACT);
    vblank = (v_q >= V_ACT);
    de     = ~hblank & ~vblank;

    unique case (bar_q)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase

    rgb_d = '0;
    if (de) begin
      unique case (pat_d)
        PAT_SOLID: rgb_d = color_d;
        PAT_BARS:  rgb_d = bar_rgb;
        PAT_GRID:  rgb_d = ((gx_q == '0) || (gy_q == '0)) ? 24'hFFFFFF : 24'h000000;
        default:   rgb_d = {lfsr_cur[7:0], lfsr_cur[15:8], lfsr_cur[7:0]};
      endcase
    end

    blank_d = {vblank, hblank};
    sync_d  = {de,
               ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL,
               ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL};
    fs_d    = frame_start;
    lfsr_d  = de ? {lfsr_cur[14:0], lfsr_cur[15] ^ lfsr_cur[13] ^ lfsr_cur[12] ^ lfsr_cur[10]}
                 : lfsr_cur;

    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + 12'd1;
    v_d    = v_q;
    gy_d   = gy_q;
    gx_d   = (h_wrap || (gx_q == GRID_LAST)) ? '0 : gx_q + 12'd1;
    if (h_wrap) begin
      v_d  = (v_q == V_LAST) ? '0 : v_q + 12'd1;
      gy_d = ((v_q == V_LAST) || (gy_q == GRID_LAST)) ? '0 : gy_q + 12'd1;
    end

    // Bar index steps every H_ACTIVE/8 pixels; it runs on through blanking harmlessly.
    bx_d  = bx_q + 12'd1;
    bar_d = bar_q;
    if (h_wrap) begin
      bx_d  = '0;
      bar_d = '0;
    end else if (bx_q == BAR_LAST) begin
      bx_d  = '0;
      bar_d = bar_q + 3'd1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q     <= '0;
      v_q     <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      bx_q    <= '0;
      bar_q   <= '0;
      pat_q   <= PAT_SOLID;
      color_q <= '0;
      lfsr_q  <= 16'h0001;
      blank_q <= 2'b11;
      sync_q  <= {1'b0, ~SYNC_POL, ~SYNC_POL};
      rgb_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else if (cen_i) begin
      h_q     <= h_d;
      v_q     <= v_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      bx_q    <= bx_d;
      bar_q   <= bar_d;
      pat_q   <= pat_d;
      color_q <= color_d;
      lfsr_q  <= lfsr_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
      rgb_q   <= rgb_d;
      x_q     <= h_q;
      y_q     <= v_q;
      fs_q    <= fs_d;
    end
  end

  assign vh_blank_o    = blank_q;
  assign dvh_sync_o    = sync_q;
  assign vid_rgb_o     = rgb_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen on a reduced raster, compared each clock
// against a pixel-level model computed from raster arithmetic.
module tb_video_timing_gen;

  localparam int   HA = 40, HF = 4, HS = 3, HB = 5;
  localparam int   VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int   GR = 5;
  localparam logic POL = 1'b0;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   BW = HA / 8;
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_i, cen_i;
  logic [1:0]  pat_sel_i;
  logic [23:0] color_i;
  logic [15:0] seed_i;
  logic [1:0]  vh_blank_o;
  logic [2:0]  dvh_sync_o;
  logic [23:0] vid_rgb_o;
  logic [11:0] x_o, y_o;
  logic        frame_start_o;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .GRID(GR)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .cen_i(cen_i),
    .pat_sel_i(pat_sel_i), .color_i(color_i), .seed_i(seed_i),
    .vh_blank_o(vh_blank_o), .dvh_sync_o(dvh_sync_o), .vid_rgb_o(vid_rgb_o),
    .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: raster position, per-frame latched selection, expected outputs.
  int          mh, mv;
  logic [1:0]  m_pat;
  logic [23:0] m_color;
  logic [15:0] m_lfsr;
  logic [1:0]  e_blank;
  logic [2:0]  e_sync;
  logic [23:0] e_rgb;
  logic [11:0] e_x, e_y;
  logic        e_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; m_pat = 2'd0; m_color = '0;
    e_blank = 2'b11; e_sync = {1'b0, ~POL, ~POL}; e_rgb = '0;
    e_x = '0; e_y = '0; e_fs = 1'b0;
  endtask

  task automatic model_pixel();
    logic de;
    if (mh == 0 && mv == 0) begin
      m_pat   = pat_sel_i;
      m_color = color_i;
      m_lfsr  = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    end
    de      = (mh < HA) && (mv < VA);
    e_blank = {mv >= VA, mh >= HA};
    e_sync  = {de,
               (mv >= VA + VF && mv < VA + VF + VS) ? POL : ~POL,
               (mh >= HA + HF && mh < HA + HF + HS) ? POL : ~POL};
    e_x  = 12'(mh);
    e_y  = 12'(mv);
    e_fs = (mh == 0 && mv == 0);
    e_rgb = '0;
    if (de) begin
      case (m_pat)
        2'd0: e_rgb = m_color;
        2'd1: e_rgb = BAR_RGB[mh / BW];
        2'd2: e_rgb = ((mh % GR == 0) || (mv % GR == 0)) ? 24'hFFFFFF : 24'h000000;
        default: e_rgb = {m_lfsr[7:0], m_lfsr[15:8], m_lfsr[7:0]};
      endcase
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    mh = mh + 1;
    if (mh == HT) begin
      mh = 0;
      mv = (mv + 1) % VT;
    end
  endtask

  task automatic step();
    if (rst_i) model_reset();
    else if (cen_i) model_pixel();
    @(posedge clk);
    #1;
    cyc++;
    check("vh_blank", 32'(vh_blank_o), 32'(e_blank));
    check("dvh_sync", 32'(dvh_sync_o), 32'(e_sync));
    check("vid_rgb", 32'(vid_rgb_o), 32'(e_rgb));
    check("x", 32'(x_o), 32'(e_x));
    check("y", 32'(y_o), 32'(e_y));
    check("frame_start", 32'(frame_start_o), 32'(e_fs));
  endtask

  task automatic rand_inputs();
    pat_sel_i = 2'($urandom_range(0, 3));
    color_i   = 24'($urandom);
    seed_i    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
  endtask

  initial begin
    int last_fs, vs_cnt, hs_cnt, cnt;
    rst_i = 1'b1; cen_i = 1'b1;
    pat_sel_i = 2'd3; color_i = 24'h123456; seed_i = 16'hACE1;
    repeat (3) step();

    // First pixel after release: (0,0), data enable, noise seeded from seed_i.
    rst_i = 1'b0;
    step();
    check("first_rgb", 32'(vid_rgb_o), 32'h00E1ACE1);
    check("first_de", 32'(dvh_sync_o[2]), 32'd1);
    check("first_fs", 32'(frame_start_o), 32'd1);
    check("first_xy", {8'd0, y_o, x_o}, 32'd0);

    // Continuous enable for three frames with random mid-frame selection changes.
    last_fs = cyc; vs_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      if ($urandom_range(0, 99) == 0) rand_inputs();
      step();
      if (dvh_sync_o[1] == POL) vs_cnt++;
      if (dvh_sync_o[0] == POL) hs_cnt++;
      if (frame_start_o) begin
        check("fs_period", 32'(cyc - last_fs), 32'(HT * VT));
        check("vsync_outputs", 32'(vs_cnt), 32'(VS * HT));
        check("hsync_outputs", 32'(hs_cnt), 32'(HS * VT));
        last_fs = cyc; vs_cnt = 0; hs_cnt = 0;
      end
    end

    // Deferred selection: bars requested mid-frame must only appear next frame.
    pat_sel_i = 2'd0; color_i = 24'h5A3C7E;
    cnt = 0;
    while (!(mh == 0 && mv == 0) && cnt < 2 * HT * VT) begin step(); cnt++; end
    step();
    for (int i = 0; i < HT * (VT / 2); i++) step();
    pat_sel_i = 2'd1;
    cnt = 0;
    while (!frame_start_o && cnt < 2 * HT * VT) begin step(); cnt++; end
    check("bars_after_defer", 32'(vid_rgb_o), 32'hFFFFFF);
    for (int i = 0; i < BW; i++) step();
    check("bar1_at_boundary", 32'(vid_rgb_o), 32'hFFFF00);

    // One-in-three enable, then a reset in mid-frame.
    for (int i = 0; i < 3 * HT * VT; i++) begin
      cen_i = (i % 3 == 0);
      if ($urandom_range(0, 149) == 0) rand_inputs();
      step();
    end
    cen_i = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    check("restart_xy", {8'd0, y_o, x_o}, 32'd0);

    // Random enable, random inputs, occasional resets.
    for (int i = 0; i < 2500; i++) begin
      cen_i = ($urandom_range(0, 1) == 1);
      rst_i = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
